// File: rtl/rf_write_arbiter_if.sv
// Bundle of the writeback request, register-file write port and scoreboard
// signals shared between the writeback sources and rf_write_arbiter.
interface rf_write_arbiter_if #(
    parameter int NREQ = 3
);
    logic [NREQ-1:0]    req_valid;
    logic [NREQ*5-1:0]  req_addr;
    logic [NREQ*32-1:0] req_data;
    logic [NREQ-1:0]    req_ready;
    logic               we3;
    logic [4:0]         wa3;
    logic [31:0]        wd3;
    logic               rsv_valid;
    logic [4:0]         rsv_addr;
    logic [31:0]        busy;
    logic               idle;

    // Sources and issue logic drive requests and reservations.
    modport master (
        output req_valid, req_addr, req_data, rsv_valid, rsv_addr,
        input  req_ready, we3, wa3, wd3, busy, idle
    );

    // The arbiter consumes requests and owns the write port and scoreboard.
    modport slave (
        input  req_valid, req_addr, req_data, rsv_valid, rsv_addr,
        output req_ready, we3, wa3, wd3, busy, idle
    );
endinterface

// File: rtl/rf_write_arbiter.sv
// Register-file write-port arbiter: one holding buffer per writeback source,
// round-robin drain of one buffered write per cycle onto we3/wa3/wd3, and a
// 32-entry scoreboard of reserved-but-unwritten destination registers.
module rf_write_arbiter #(
    parameter int NREQ    = 3,
    parameter int RR_INIT = 0
) (
    input logic               clk,
    input logic               reset,
    rf_write_arbiter_if.slave bus
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0] r_full;
    logic [4:0]      r_bufAddr [NREQ];
    logic [31:0]     r_bufData [NREQ];
    logic [PW-1:0]   r_ptr;
    logic [31:0]     r_busy;

    logic [NREQ-1:0] w_grant;
    logic [PW-1:0]   w_grantIdx;
    logic            w_anyGrant;
    logic [NREQ-1:0] w_ready;
    logic [NREQ-1:0] w_take;
    logic            w_we3;
    logic [4:0]      w_wa3;
    logic [31:0]     w_wd3;
    logic [31:0]     w_busyNext;

    // Requester index reached by stepping 'offset' places past 'base', wrapping.
    function automatic logic [PW-1:0] wrapIdx(input int base, input int offset);
        return PW'((base + offset) % NREQ);
    endfunction

    // Round-robin search from the pointer; first full buffer wins the port.
    always_comb begin
        w_anyGrant = 1'b0;
        w_grantIdx = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!w_anyGrant && r_full[wrapIdx(int'(r_ptr), k)]) begin
                w_anyGrant = 1'b1;
                w_grantIdx = wrapIdx(int'(r_ptr), k);
            end
        end
        w_grant = w_anyGrant ? (NREQ'(1) << w_grantIdx) : '0;
    end

    // A buffer being drained this cycle can be refilled at the same edge.
    assign w_ready = ~r_full | w_grant;
    assign w_take  = bus.req_valid & w_ready;

    // Write port comes only from registered state; r0 writes drain silently
    // and reset keeps the enable low so the regfile reset is never overridden.
    assign w_we3 = w_anyGrant & (r_bufAddr[w_grantIdx] != 5'd0) & ~reset;
    assign w_wa3 = w_anyGrant ? r_bufAddr[w_grantIdx] : 5'd0;
    assign w_wd3 = w_anyGrant ? r_bufData[w_grantIdx] : 32'd0;

    // Scoreboard update: clear on write, then a same-register reservation wins.
    always_comb begin
        w_busyNext = r_busy;
        if (w_we3) begin
            w_busyNext[w_wa3] = 1'b0;
        end
        if (bus.rsv_valid && (bus.rsv_addr != 5'd0)) begin
            w_busyNext[bus.rsv_addr] = 1'b1;
        end
        w_busyNext[0] = 1'b0;
    end

    // Buffer occupancy and round-robin pointer; reset discards pending writes.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_full <= '0;
            r_ptr  <= PW'(RR_INIT);
            r_busy <= '0;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (w_take[i]) begin
                    r_full[i] <= 1'b1;
                end else if (w_grant[i]) begin
                    r_full[i] <= 1'b0;
                end
            end
            if (w_anyGrant) begin
                r_ptr <= wrapIdx(int'(w_grantIdx), 1);
            end
            r_busy <= w_busyNext;
        end
    end

    // Capture offered address/data whenever a handshake completes.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NREQ; i++) begin
            if (w_take[i]) begin
                r_bufAddr[i] <= bus.req_addr[5*i +: 5];
                r_bufData[i] <= bus.req_data[32*i +: 32];
            end
        end
    end

    assign bus.req_ready = w_ready;
    assign bus.we3       = w_we3;
    assign bus.wa3       = w_wa3;
    assign bus.wd3       = w_wd3;
    assign bus.busy      = r_busy;
    assign bus.idle      = ~|r_full;
endmodule

// File: tb/tb_rf_write_arbiter.sv
// Bench for rf_write_arbiter: directed scenarios with literal expectations
// plus a per-cycle comparison against a behavioural model of the arbiter.
module tb_rf_write_arbiter;
    localparam int NREQ    = 3;
    localparam int RR_INIT = 0;

    logic clk;
    logic reset;
    int   nVec  = 0;
    int   nMiss = 0;

    rf_write_arbiter_if #(.NREQ(NREQ)) bus ();

    rf_write_arbiter #(.NREQ(NREQ), .RR_INIT(RR_INIT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model state: one pending write per source, a pointer and the busy set.
    bit          mFull [NREQ];
    logic [4:0]  mAddr [NREQ];
    logic [31:0] mData [NREQ];
    int          mPtr = RR_INIT;
    logic [31:0] mBusy = '0;

    // Which source owns the port: first pending source at or after the pointer.
    function automatic int modelGrant();
        for (int k = 0; k < NREQ; k++) begin
            if (mFull[(mPtr + k) % NREQ]) return (mPtr + k) % NREQ;
        end
        return -1;
    endfunction

    // Record one comparison, reporting it when the DUT disagrees.
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nVec++;
        if (act !== exp) begin
            nMiss++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance the model at each rising edge from the inputs seen there.
    always @(posedge clk) begin
        int g;
        bit weNow;
        logic [4:0] waNow;
        bit takeNow [NREQ];
        g = modelGrant();
        weNow = 1'b0;
        waNow = 5'd0;
        if (g >= 0) begin
            waNow = mAddr[g];
            weNow = (mAddr[g] != 5'd0) && !reset;
        end
        for (int i = 0; i < NREQ; i++) begin
            takeNow[i] = bus.req_valid[i] && (!mFull[i] || g == i);
        end
        if (reset) begin
            for (int i = 0; i < NREQ; i++) mFull[i] = 1'b0;
            mPtr  = RR_INIT;
            mBusy = '0;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (takeNow[i]) begin
                    mFull[i] = 1'b1;
                    mAddr[i] = bus.req_addr[5*i +: 5];
                    mData[i] = bus.req_data[32*i +: 32];
                end else if (g == i) begin
                    mFull[i] = 1'b0;
                end
            end
            if (g >= 0) mPtr = (g + 1) % NREQ;
            if (weNow) mBusy[waNow] = 1'b0;
            if (bus.rsv_valid && bus.rsv_addr != 5'd0) mBusy[bus.rsv_addr] = 1'b1;
        end
    end

    // Compare every output against the model mid-cycle, after inputs settle.
    always @(negedge clk) begin
        int g;
        logic        expWe;
        logic [4:0]  expWa;
        logic [31:0] expWd;
        logic [NREQ-1:0] expReady;
        bit anyFull;
        #2;
        g = modelGrant();
        expWe = 1'b0;
        expWa = 5'd0;
        expWd = 32'd0;
        if (g >= 0) begin
            expWa = mAddr[g];
            expWd = mData[g];
            expWe = (mAddr[g] != 5'd0) && !reset;
        end
        anyFull = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            expReady[i] = !mFull[i] || (g == i);
            if (mFull[i]) anyFull = 1'b1;
        end
        checkOutput("model we3", {31'd0, bus.we3}, {31'd0, expWe});
        checkOutput("model wa3", {27'd0, bus.wa3}, {27'd0, expWa});
        checkOutput("model wd3", bus.wd3, expWd);
        checkOutput("model req_ready", {29'd0, bus.req_ready}, {29'd0, expReady});
        checkOutput("model busy", bus.busy, mBusy);
        checkOutput("model idle", {31'd0, bus.idle}, {31'd0, !anyFull});
    end

    // Drive one cycle of inputs at the falling edge, then let outputs settle.
    task automatic applyStimulus(input logic rst, input logic [NREQ-1:0] v,
                                 input logic [4:0] a0, input logic [4:0] a1, input logic [4:0] a2,
                                 input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2,
                                 input logic rv, input logic [4:0] ra);
        @(negedge clk);
        reset         = rst;
        bus.req_valid = v;
        bus.req_addr  = {a2, a1, a0};
        bus.req_data  = {d2, d1, d0};
        bus.rsv_valid = rv;
        bus.rsv_addr  = ra;
        #3;
    endtask

    task automatic applyIdle();
        applyStimulus(1'b0, 3'b000, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 1'b0, 5'd0);
    endtask

    // Directed scenarios followed by a short pseudo-random soak.
    initial begin
        reset         = 1'b1;
        bus.req_valid = '1;
        bus.req_addr  = {5'd3, 5'd2, 5'd1};
        bus.req_data  = '0;
        bus.rsv_valid = 1'b0;
        bus.rsv_addr  = 5'd0;

        // Reset held two cycles with every source offering.
        applyStimulus(1'b1, 3'b111, 5'd1, 5'd2, 5'd3, 32'hA, 32'hB, 32'hC, 1'b0, 5'd0);
        checkOutput("reset we3", {31'd0, bus.we3}, 32'd0);
        checkOutput("reset busy", bus.busy, 32'd0);
        checkOutput("reset idle", {31'd0, bus.idle}, 32'd1);
        checkOutput("reset ready", {29'd0, bus.req_ready}, 32'd7);
        applyStimulus(1'b1, 3'b111, 5'd1, 5'd2, 5'd3, 32'hA, 32'hB, 32'hC, 1'b0, 5'd0);
        checkOutput("reset we3 2", {31'd0, bus.we3}, 32'd0);

        // Three-way contention from the reset pointer.
        applyStimulus(1'b0, 3'b111, 5'd1, 5'd2, 5'd3, 32'hA, 32'hB, 32'hC, 1'b0, 5'd0);
        applyIdle();
        checkOutput("contend wa3 #1", {27'd0, bus.wa3}, 32'd1);
        checkOutput("contend wd3 #1", bus.wd3, 32'hA);
        checkOutput("contend ready", {29'd0, bus.req_ready}, 32'd1);
        applyIdle();
        checkOutput("contend wa3 #2", {27'd0, bus.wa3}, 32'd2);
        applyStimulus(1'b0, 3'b110, 5'd0, 5'd10, 5'd11, 32'd0, 32'h10, 32'h11, 1'b0, 5'd0);
        checkOutput("contend wa3 #3", {27'd0, bus.wa3}, 32'd3);
        applyIdle();
        checkOutput("wrap wa3 #1", {27'd0, bus.wa3}, 32'd10);
        applyIdle();
        checkOutput("wrap wa3 #2", {27'd0, bus.wa3}, 32'd11);

        // Single source streaming back-to-back.
        applyStimulus(1'b0, 3'b001, 5'd5, 5'd0, 5'd0, 32'h11, 32'd0, 32'd0, 1'b0, 5'd0);
        applyStimulus(1'b0, 3'b001, 5'd6, 5'd0, 5'd0, 32'h22, 32'd0, 32'd0, 1'b0, 5'd0);
        checkOutput("stream wa3 r5", {27'd0, bus.wa3}, 32'd5);
        checkOutput("stream ready0", {31'd0, bus.req_ready[0]}, 32'd1);
        applyStimulus(1'b0, 3'b001, 5'd7, 5'd0, 5'd0, 32'h33, 32'd0, 32'd0, 1'b0, 5'd0);
        checkOutput("stream wa3 r6", {27'd0, bus.wa3}, 32'd6);
        applyIdle();
        checkOutput("stream wa3 r7", {27'd0, bus.wa3}, 32'd7);
        checkOutput("stream wd3 r7", bus.wd3, 32'h33);
        applyIdle();
        checkOutput("stream done idle", {31'd0, bus.idle}, 32'd1);

        // Write to r0 drains without enabling the port.
        applyStimulus(1'b0, 3'b010, 5'd0, 5'd0, 5'd0, 32'd0, 32'hDEAD, 32'd0, 1'b0, 5'd0);
        applyIdle();
        checkOutput("r0 we3", {31'd0, bus.we3}, 32'd0);
        checkOutput("r0 wd3", bus.wd3, 32'hDEAD);
        checkOutput("r0 pending", {31'd0, bus.idle}, 32'd0);
        applyIdle();
        checkOutput("r0 drained", {31'd0, bus.idle}, 32'd1);
        checkOutput("r0 busy", bus.busy, 32'd0);

        // Reserve r9, then write r9 and watch it clear.
        applyStimulus(1'b0, 3'b000, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 1'b1, 5'd9);
        applyStimulus(1'b0, 3'b100, 5'd0, 5'd0, 5'd9, 32'd0, 32'd0, 32'h99, 1'b0, 5'd0);
        checkOutput("sb reserved r9", bus.busy, 32'h0000_0200);
        applyIdle();
        checkOutput("sb write r9 we3", {31'd0, bus.we3}, 32'd1);
        checkOutput("sb r9 still busy", bus.busy, 32'h0000_0200);
        applyIdle();
        checkOutput("sb r9 cleared", bus.busy, 32'd0);

        // Reserve r4 at the same edge its write drains: reservation survives.
        applyStimulus(1'b0, 3'b001, 5'd4, 5'd0, 5'd0, 32'h44, 32'd0, 32'd0, 1'b0, 5'd0);
        applyStimulus(1'b0, 3'b000, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 1'b1, 5'd4);
        checkOutput("sb r4 write wa3", {27'd0, bus.wa3}, 32'd4);
        applyIdle();
        checkOutput("sb r4 set wins", bus.busy, 32'h0000_0010);

        // Reset mid-burst discards two pending writes and rewinds the pointer.
        applyStimulus(1'b0, 3'b011, 5'd12, 5'd13, 5'd0, 32'h12, 32'h13, 32'd0, 1'b0, 5'd0);
        applyStimulus(1'b1, 3'b000, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 1'b0, 5'd0);
        checkOutput("midreset we3", {31'd0, bus.we3}, 32'd0);
        applyStimulus(1'b0, 3'b101, 5'd16, 5'd0, 5'd17, 32'h16, 32'd0, 32'h17, 1'b0, 5'd0);
        checkOutput("midreset idle", {31'd0, bus.idle}, 32'd1);
        checkOutput("midreset we3 after", {31'd0, bus.we3}, 32'd0);
        checkOutput("midreset busy", bus.busy, 32'd0);
        applyIdle();
        checkOutput("midreset ptr wa3", {27'd0, bus.wa3}, 32'd16);
        applyIdle();
        checkOutput("midreset next wa3", {27'd0, bus.wa3}, 32'd17);

        // Pseudo-random soak checked by the model.
        for (int n = 0; n < 80; n++) begin
            applyStimulus($urandom_range(0, 29) == 0, 3'($urandom_range(0, 7)),
                          5'($urandom), 5'($urandom), 5'($urandom),
                          $urandom, $urandom, $urandom,
                          $urandom_range(0, 1) == 1, 5'($urandom));
        end
        for (int n = 0; n < NREQ + 1; n++) applyIdle();
        checkOutput("soak drained", {31'd0, bus.idle}, 32'd1);

        @(negedge clk);
        #4;
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMiss);
        $finish;
    end
endmodule
